// File: rtl/instruction_fetch_queue.sv
// Fetch stage: issues in-order word requests to imem and buffers {pc, instr} responses for decode.
// Optional IFQ_PERF_EN adds fetch_starve_cnt (cycles decode waited on an empty queue).
module instruction_fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_instr,
  output logic [PC_W-1:0] dec_pc
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0]     fetch_starve_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshakes: a transfer happens on a cycle where valid && ready are both high;
  // valid never depends on ready, and redirect_valid cancels the request and the pop.
  logic [PC_W-1:0] r_pc;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_tag_rd;
  logic [AW-1:0]   r_tag_wr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [31:0]     r_instr_mem [DEPTH];
  logic [PC_W-1:0] r_pc_mem    [DEPTH];
  logic [PC_W-1:0] r_tag_mem   [DEPTH];

  logic [CW:0]     w_inflight;
  logic            w_req_fire;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_unused_redirect_lo;

  assign w_unused_redirect_lo = redirect_pc[1:0];

  // Queued plus in-flight entries never exceed DEPTH, so every response has a slot.
  assign w_inflight     = (CW+1)'(r_outstanding) + (CW+1)'(r_count);
  assign imem_req_valid = rst_n && !redirect_valid && (w_inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign dec_valid = (r_count != '0);
  assign dec_instr = r_instr_mem[r_rd_ptr];
  assign dec_pc    = r_pc_mem[r_rd_ptr];

  assign w_push = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
  assign w_pop  = dec_valid && dec_ready && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_tag_rd      <= '0;
      r_tag_wr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
      // Tag FIFO tracks every issued request, stale or not, so it stays aligned with responses.
      if (w_req_fire)     r_tag_wr <= r_tag_wr + AW'(1);
      if (imem_rsp_valid) r_tag_rd <= r_tag_rd + AW'(1);
      if (redirect_valid) begin
        r_pc       <= {redirect_pc[PC_W-1:2], 2'b00};
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_drop_cnt <= r_outstanding - CW'(imem_rsp_valid);
      end else begin
        if (w_req_fire) r_pc     <= r_pc + PC_W'(4);
        if (w_push)     r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)      r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire) r_tag_mem[r_tag_wr] <= r_pc;
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_tag_mem[r_tag_rd];
      r_instr_mem[r_wr_ptr] <= imem_rsp_data;
    end
  end

`ifdef IFQ_PERF_EN
  logic [31:0] r_starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (dec_ready && !dec_valid && !redirect_valid && (r_starve_cnt != 32'hFFFF_FFFF)) begin
      r_starve_cnt <= r_starve_cnt + 32'd1;
    end
  end

  assign fetch_starve_cnt = r_starve_cnt;
`endif

endmodule
